// File: rtl/mv_search_ctrl.sv
// rtl/mv_search_ctrl.sv - load/search sequencer for the motion-vector block-matching datapath
module mv_search_ctrl #(
    parameter int SEARCH_R = 4,
    parameter int LOAD_PIX = 256,
    parameter int SAD_W    = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              start,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              cand_valid,
    input  logic              cand_ready,
    output logic [3:0]        cand_dx,
    output logic [3:0]        cand_dy,
    input  logic              sad_valid,
    input  logic [SAD_W-1:0]  sad_in,
    output logic [15:0]       mv_out,
    output logic [SAD_W-1:0]  best_sad,
    output logic              mv_valid,
    output logic              busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int                 TOTAL     = (2 * SEARCH_R + 1) * (2 * SEARCH_R + 1);
    localparam logic signed [3:0]  R_POS     = 4'(SEARCH_R);
    localparam logic signed [3:0]  R_NEG     = 4'(-SEARCH_R);
    localparam logic [ADDR_W-1:0]  LOAD_LAST = ADDR_W'(LOAD_PIX - 1);
    localparam logic [7:0]         RET_ALL   = 8'(TOTAL);
    localparam logic [7:0]         RET_LAST  = 8'(TOTAL - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] load_cnt;
    logic signed [3:0] cdx, cdy;
    logic signed [3:0] rdx, rdy;
    logic signed [3:0] bdx, bdy;
    logic [7:0]        ret_cnt;
    logic [SAD_W-1:0]  best_sad_r;

    logic cand_fire, cand_last, ret_fire, ret_done;

    assign cand_fire = (state == S_SEARCH) && cand_ready;
    assign cand_last = (cdx == R_POS) && (cdy == R_POS);
    // Results are only accepted while a search is in flight and the total has not been reached.
    assign ret_fire  = ((state == S_SEARCH) || (state == S_DRAIN)) && sad_valid && (ret_cnt != RET_ALL);
    assign ret_done  = ret_fire && (ret_cnt == RET_LAST);

    assign busy       = (state != S_IDLE);
    assign pix_ready  = (state == S_LOAD);
    assign buf_we     = pix_ready && pix_valid;
    assign buf_addr   = load_cnt;
    assign buf_wdata  = buf_we ? pix_in : 8'd0;
    assign cand_valid = (state == S_SEARCH);
    assign cand_dx    = cdx;
    assign cand_dy    = cdy;
    assign mv_out     = {{4{bdx[3]}}, bdx, {4{bdy[3]}}, bdy};
    assign best_sad   = best_sad_r;
    assign mv_valid   = (state == S_DONE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= S_IDLE;
            load_cnt   <= '0;
            cdx        <= '0;
            cdy        <= '0;
            rdx        <= '0;
            rdy        <= '0;
            bdx        <= '0;
            bdy        <= '0;
            ret_cnt    <= '0;
            best_sad_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        load_cnt   <= '0;
                        cdx        <= R_NEG;
                        cdy        <= R_NEG;
                        rdx        <= R_NEG;
                        rdy        <= R_NEG;
                        bdx        <= '0;
                        bdy        <= '0;
                        ret_cnt    <= '0;
                        best_sad_r <= '1;
                    end
                end
                S_LOAD: begin
                    if (pix_valid) begin
                        if (load_cnt == LOAD_LAST) begin
                            load_cnt <= '0;
                            state    <= S_SEARCH;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (cand_fire) begin
                        if (cdx == R_POS) begin
                            cdx <= R_NEG;
                            cdy <= cdy + 4'sd1;
                        end else begin
                            cdx <= cdx + 4'sd1;
                        end
                        if (cand_last) begin
                            state <= ret_done ? S_DONE : S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ret_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Return-side coordinates mirror the issue raster, so results pair with vectors by order.
            if (ret_fire) begin
                if (sad_in < best_sad_r) begin
                    best_sad_r <= sad_in;
                    bdx        <= rdx;
                    bdy        <= rdy;
                end
                if (rdx == R_POS) begin
                    rdx <= R_NEG;
                    rdy <= rdy + 4'sd1;
                end else begin
                    rdx <= rdx + 4'sd1;
                end
                ret_cnt <= ret_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mv_search_ctrl.sv
// tb/tb_mv_search_ctrl.sv - self-checking bench for mv_search_ctrl
`timescale 1ns/1ps
module tb_mv_search_ctrl;

    localparam int R = 4;
    localparam int N = 81;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        buf_we;
    logic [7:0]  buf_addr;
    logic [7:0]  buf_wdata;
    logic        cand_valid;
    logic        cand_ready = 1'b1;
    logic [3:0]  cand_dx, cand_dy;
    logic        sad_valid = 1'b0;
    logic [15:0] sad_in = 16'd0;
    logic [15:0] mv_out;
    logic [15:0] best_sad;
    logic        mv_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] sad_map [9][9];

    typedef struct {
        logic [15:0] dflt;
        int          ax, ay;
        logic [15:0] av;
        int          bx, by;
        logic [15:0] bv;
        int          lat, stall_at, stall_len, start_at;
        logic [15:0] exp_mv, exp_best;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] sad;
    } ret_t;

    always #5 clk = ~clk;

    mv_search_ctrl dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .cand_valid(cand_valid),
        .cand_ready(cand_ready),
        .cand_dx   (cand_dx),
        .cand_dy   (cand_dy),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .mv_out    (mv_out),
        .best_sad  (best_sad),
        .mv_valid  (mv_valid),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_map(input logic [15:0] d, input int ax, input int ay, input logic [15:0] av,
                           input int bx, input int by, input logic [15:0] bv);
        for (int y = 0; y < 9; y++)
            for (int x = 0; x < 9; x++)
                sad_map[y][x] = d;
        sad_map[ay + R][ax + R] = av;
        sad_map[by + R][bx + R] = bv;
    endtask

    // Reference: scan the raster, strict less-than keeps the earliest of equal minima.
    task automatic ref_search(output logic [15:0] mv, output logic [15:0] best);
        best = 16'hFFFF;
        mv   = 16'h0000;
        for (int y = 0; y < 9; y++)
            for (int x = 0; x < 9; x++)
                if (sad_map[y][x] < best) begin
                    best = sad_map[y][x];
                    mv   = {8'(x - R), 8'(y - R)};
                end
    endtask

    task automatic do_load(input bit gaps, input string tag);
        int  wr = 0;
        int  cyc = 0;
        bit  ok = 1'b1;
        bit  tog = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (wr < 256 && cyc < 2000) begin
            pix_valid = gaps ? tog : 1'b1;
            tog       = ~tog;
            pix_in    = 8'($urandom);
            @(negedge clk);
            if (pix_ready !== 1'b1 || cand_valid !== 1'b0 || buf_we !== pix_valid) ok = 1'b0;
            if (buf_we === 1'b1) begin
                if (buf_addr !== 8'(wr) || buf_wdata !== pix_in) ok = 1'b0;
                wr++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        @(negedge clk);
        chk({tag, " load order"}, 32'(ok), 32'd1);
        chk({tag, " load writes"}, 32'(wr), 32'd256);
        chk({tag, " search entered"}, {28'd0, pix_ready, cand_valid, cand_dx == 4'hC, cand_dy == 4'hC}, 32'h7);
    endtask

    task automatic do_search(input int lat, input int stall_at, input int stall_len, input bit rnd_ready,
                             input int start_at, input int abort_at,
                             input logic [15:0] exp_mv, input logic [15:0] exp_best, input string tag);
        ret_t pend[$];
        int   iss = 0, rets = 0, mvv = 0, cyc = 0, stall = 0, after = 0;
        bit   order_ok = 1'b1, stalled = 1'b0, aborted = 1'b0;
        while (cyc < 3000 && after < 4) begin
            if (cand_valid === 1'b1 && cand_ready === 1'b1) begin
                int ix = int'($signed(cand_dx)) + R;
                int iy = int'($signed(cand_dy)) + R;
                if (cand_dx !== 4'(iss % 9 - R) || cand_dy !== 4'(iss / 9 - R)) order_ok = 1'b0;
                if (ix < 0 || ix > 8 || iy < 0 || iy > 8) begin
                    order_ok = 1'b0;
                    ix = 0;
                    iy = 0;
                end
                pend.push_back('{cyc + lat - 1, sad_map[iy][ix]});
                iss++;
            end
            if (mv_valid === 1'b1) begin
                mvv++;
                chk({tag, " mv_out"}, 32'(mv_out), 32'(exp_mv));
                chk({tag, " best_sad"}, 32'(best_sad), 32'(exp_best));
            end
            if (mvv > 0) after++;
            @(posedge clk); #1;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " abort outputs"},
                    {25'd0, busy, cand_valid, mv_valid, pix_ready, buf_we, |mv_out, |best_sad}, 32'd0);
                aborted = 1'b1;
                sad_valid = 1'b0;
                break;
            end
            sad_valid = 1'b0;
            sad_in    = 16'($urandom);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                sad_valid = 1'b1;
                sad_in    = pend[0].sad;
                void'(pend.pop_front());
                rets++;
            end
            if (stall_at >= 0 && iss == stall_at && !stalled) begin
                stall   = stall_len;
                stalled = 1'b1;
            end
            if (stall > 0) begin
                cand_ready = 1'b0;
                stall--;
            end else begin
                cand_ready = rnd_ready ? ($urandom % 4 != 0) : 1'b1;
            end
            start = (cyc == start_at);
            cyc++;
            @(negedge clk);
        end
        sad_valid  = 1'b0;
        start      = 1'b0;
        cand_ready = 1'b1;
        if (!aborted) begin
            chk({tag, " raster order"}, 32'(order_ok), 32'd1);
            chk({tag, " issued"}, 32'(iss), 32'(N));
            chk({tag, " results"}, 32'(rets), 32'(N));
            chk({tag, " pending left"}, 32'(pend.size()), 32'd0);
            chk({tag, " mv_valid pulses"}, 32'(mvv), 32'd1);
            chk({tag, " idle after"}, {31'd0, busy}, 32'd0);
            chk({tag, " mv_out held"}, {mv_out, best_sad}, {exp_mv, exp_best});
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] emv, ebest;
        int          bad;

        vecs[0] = '{16'd1000,  2, -3, 16'd17,    2, -3, 16'd17,    1, -1, 0, -1, 16'h02FD, 16'd17};
        vecs[1] = '{16'd100,  -1,  0, 16'd5,     3,  1, 16'd5,     2, -1, 0, -1, 16'hFF00, 16'd5};
        vecs[2] = '{16'd1000,  2, -3, 16'd17,    2, -3, 16'd17,    4, 40, 3, -1, 16'h02FD, 16'd17};
        vecs[3] = '{16'd1000,  2, -3, 16'd17,    2, -3, 16'd17,    3, -1, 0, 10, 16'h02FD, 16'd17};
        vecs[4] = '{16'hFFFF,  4,  4, 16'hFFFE,  4,  4, 16'hFFFE,  5, -1, 0, -1, 16'h0404, 16'hFFFE};
        vecs[5] = '{16'd50,   -4, -4, 16'd0,     0,  0, 16'd0,     1, -1, 0, -1, 16'hFCFC, 16'd0};

        #1;
        chk("reset outputs",
            {22'd0, busy, pix_ready, buf_we, cand_valid, mv_valid, |buf_addr, |mv_out, |best_sad, |cand_dx, |cand_dy},
            32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            set_map(vecs[i].dflt, vecs[i].ax, vecs[i].ay, vecs[i].av, vecs[i].bx, vecs[i].by, vecs[i].bv);
            do_load(i % 2 == 0, $sformatf("vec%0d", i));
            do_search(vecs[i].lat, vecs[i].stall_at, vecs[i].stall_len, 1'b0, vecs[i].start_at, -1,
                      vecs[i].exp_mv, vecs[i].exp_best, $sformatf("vec%0d", i));
        end

        set_map(16'd1000, 2, -3, 16'd17, 2, -3, 16'd17);
        do_load(1'b0, "abort");
        do_search(2, -1, 0, 1'b0, -1, 20, 16'h02FD, 16'd17, "abort");
        @(posedge clk); #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            sad_valid = 1'b1;
            sad_in    = 16'd0;
            @(negedge clk);
            if (busy !== 1'b0 || mv_valid !== 1'b0 || cand_valid !== 1'b0 || best_sad !== 16'd0) bad++;
            @(posedge clk); #1;
        end
        sad_valid = 1'b0;
        chk("stray sad_valid in idle", 32'(bad), 32'd0);
        do_load(1'b1, "post-abort");
        do_search(3, -1, 0, 1'b0, -1, -1, 16'h02FD, 16'd17, "post-abort");

        for (int t = 0; t < 6; t++) begin
            for (int y = 0; y < 9; y++)
                for (int x = 0; x < 9; x++)
                    sad_map[y][x] = 16'($urandom_range(0, 40));
            ref_search(emv, ebest);
            do_load(t % 2 == 1, $sformatf("rnd%0d", t));
            do_search($urandom_range(1, 6), -1, 0, 1'b1, -1, -1, emv, ebest, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mv_search_ctrl.md
Name: mv_search_ctrl

Overview:
- Sequencer for the motion-vector block-matching datapath.
- Accepts the 8-bit pixel stream and routes it into the datapath's block/window buffer with write addresses.
- Issues every candidate displacement of a full search to the SAD unit, tracks the minimum returned SAD, and presents the winning vector as a 16-bit word for the output pads.
- Sits between the pad-side pixel input and the SAD datapath inside the motion-vector user project.

Parameters:
- SEARCH_R, 4, search range; dx, dy each span -SEARCH_R..+SEARCH_R (max 7).
- LOAD_PIX, 256, pixels per frame-pair load (current block plus search window).
- SAD_W, 16, width of SAD results.
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W >= LOAD_PIX.

Ports:
- wb_clk_i, in, 1: single clock.
- wb_rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin load+search; sampled only in IDLE.
- pix_in, in, 8: pixel data.
- pix_valid, in, 1: pixel present.
- pix_ready, out, 1: controller accepts pixel (high only in LOAD).
- buf_we, out, 1: buffer write strobe.
- buf_addr, out, ADDR_W: buffer write address.
- buf_wdata, out, 8: buffer write data.
- cand_valid, out, 1: candidate displacement offered.
- cand_ready, in, 1: SAD unit accepts candidate.
- cand_dx, out, 4: signed candidate x offset.
- cand_dy, out, 4: signed candidate y offset.
- sad_valid, in, 1: SAD result present; results return in issue order.
- sad_in, in, SAD_W: SAD result.
- mv_out, out, 16: {sign-extended dx[7:0], sign-extended dy[7:0]}.
- best_sad, out, SAD_W: minimum SAD found.
- mv_valid, out, 1: one-cycle pulse when the result is final.
- busy, out, 1: high in any state except IDLE.

Behaviour:
- Reset (async, wb_rst_n low): all state goes to IDLE; all outputs 0; counters cleared.
- Reset mid-operation aborts immediately. The datapath must not be assumed drained afterwards; subsequent sad_valid pulses in IDLE are ignored.
- FSM states: IDLE, LOAD, SEARCH, DRAIN, DONE.
- IDLE -> LOAD on start=1. start in any other state is ignored.
- LOAD:
  - pix_ready=1.
  - Each cycle with pix_valid=1: buf_we=1, buf_wdata=pix_in, buf_addr=load_cnt (combinational from the registered counter), then load_cnt increments.
  - After the LOAD_PIX-th accepted pixel, go to SEARCH next cycle; load_cnt resets to 0.
  - pix_valid gaps simply stall the load.
- SEARCH:
  - cand_valid=1 with the registered (dx,dy).
  - Raster order: dy outer loop, dx inner loop, each from -SEARCH_R to +SEARCH_R.
  - A candidate transfers when cand_valid && cand_ready; the next candidate appears the following cycle. Throughput is one per cycle.
  - dx, dy, and the issue count hold while cand_ready=0.
  - After (2*SEARCH_R+1)^2 transfers, go to DRAIN.
- Result tracking, active in SEARCH and DRAIN:
  - A return counter increments on each sad_valid.
  - A result updates best_sad and the best vector only if sad_in < best_sad (strict), so ties keep the earlier candidate in scan order.
  - best_sad is initialised to all-ones on the IDLE->LOAD transition.
  - The first result always wins unless it equals all-ones.
  - The vector paired with each result is tracked by its own return-side dx/dy counters advancing in the same raster order.
- A sad_valid in the same cycle as the last candidate issue is counted normally.
- DRAIN -> DONE when the return count reaches (2*SEARCH_R+1)^2. This transition may occur on the cycle the final result arrives, whether in SEARCH or DRAIN.
- DONE:
  - mv_valid=1 for exactly one cycle, then go to IDLE.
  - mv_out and best_sad hold until the next start.
- sad_valid outside SEARCH/DRAIN is ignored. The return count saturates at the candidate total; excess results are ignored.
- busy = (state != IDLE).

Test Plan:
- Load: start, then 256 pixels with pix_valid toggling every other cycle -> buf_addr 0..255 in order, buf_we count = 256, SEARCH entered the cycle after the last write.
- Full search: SAD model returns 1000 except 17 at (dx=+2, dy=-3) -> 81 candidates issued in raster order starting (-4,-4); mv_valid pulse; mv_out=16'h02FD; best_sad=17.
- Tie: SAD 5 at (-1,0) and at (+3,+1), 100 elsewhere -> mv_out=16'hFF00, best_sad=5.
- Backpressure: cand_ready low 3 cycles at candidate 40, with a 4-cycle SAD latency -> no candidate lost or duplicated; exactly 81 results consumed; DONE reached once.
- start pulsed during SEARCH -> ignored, no restart; single mv_valid.
- wb_rst_n asserted mid-SEARCH, then stray sad_valid pulses -> outputs 0 immediately, stays in IDLE, busy=0, no mv_valid; a following full run produces the correct result.
